// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate ops (op 110/111).
module mul_div_unit #(
    parameter int MULT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        is_signed;
`ifdef MDU_MADD_EN
    logic        accumulate;
    logic [63:0] addend;
`endif
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] mul_result;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        fits;
    logic [31:0] q_next;
    logic [31:0] r_next;
    logic [31:0] q_final;
    logic [31:0] r_final;

    always_comb begin
        ext_a = is_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
        ext_b = is_signed ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
`ifdef MDU_MADD_EN
        mul_result = ext_a * ext_b + (accumulate ? addend : 64'd0);
`else
        mul_result = ext_a * ext_b;
`endif
    end

    // One restoring-divide step; the last step also gets its sign fix here.
    always_comb begin
        shifted = {rem, quot[31]};
        trial   = shifted - {1'b0, divisor};
        fits    = (shifted >= {1'b0, divisor});
        r_next  = fits ? trial[31:0] : shifted[31:0];
        q_next  = {quot[30:0], fits};
        q_final = neg_q ? (32'd0 - q_next) : q_next;
        r_final = neg_r ? (32'd0 - r_next) : r_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 5'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state     <= MUL;
                                busy      <= 1'b1;
                                count     <= 5'(MULT_CYCLES - 1);
                                op_a      <= A;
                                op_b      <= B;
                                is_signed <= (op == OP_MULT);
`ifdef MDU_MADD_EN
                                accumulate <= 1'b0;
`endif
                            end
`ifdef MDU_MADD_EN
                            OP_MADD, OP_MADDU: begin
                                state      <= MUL;
                                busy       <= 1'b1;
                                count      <= 5'(MULT_CYCLES - 1);
                                op_a       <= A;
                                op_b       <= B;
                                is_signed  <= (op == OP_MADD);
                                accumulate <= 1'b1;
                                addend     <= {hi, lo};
                            end
`endif
                            OP_DIV, OP_DIVU: begin
                                state    <= DIV;
                                busy     <= 1'b1;
                                count    <= 5'd31;
                                rem      <= 32'd0;
                                quot     <= (op == OP_DIV && A[31]) ? (32'd0 - A) : A;
                                divisor  <= (op == OP_DIV && B[31]) ? (32'd0 - B) : B;
                                neg_q    <= (op == OP_DIV) && (A[31] ^ B[31]);
                                neg_r    <= (op == OP_DIV) && A[31];
                                div_zero <= (B == 32'd0);
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (count == 5'd0) begin
                        {hi, lo} <= mul_result;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                DIV: begin
                    quot <= q_next;
                    rem  <= r_next;
                    // Divide by zero runs the full latency but leaves HI/LO untouched.
                    if (count == 5'd0) begin
                        if (!div_zero) begin
                            hi <= r_final;
                            lo <= q_final;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; MADD checks follow MDU_MADD_EN.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nAssert = 0;
    int nFail   = 0;
    int busyCyc;
    int doneCnt;

    mul_div_unit #(.MULT_CYCLES(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle, then watch busy/done for a bounded window.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int bc, output int dc);
        bc = 0;
        dc = 0;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (done) dc++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        applyStimulus(3'b000, 32'hFFFFFFFE, 32'd3, busyCyc, doneCnt);
        checkOutput("mult_busy_cycles", busyCyc, 5);
        checkOutput("mult_done_pulses", doneCnt, 1);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFA);

        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, busyCyc, doneCnt);
        checkOutput("multu_hi", hi, 32'hFFFFFFFE);
        checkOutput("multu_lo", lo, 32'h00000001);

        applyStimulus(3'b010, 32'hFFFFFFF9, 32'd2, busyCyc, doneCnt);
        checkOutput("div_busy_cycles", busyCyc, 32);
        checkOutput("div_done_pulses", doneCnt, 1);
        checkOutput("div_neg_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_neg_hi", hi, 32'hFFFFFFFF);

        applyStimulus(3'b011, 32'd7, 32'd2, busyCyc, doneCnt);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);

        applyStimulus(3'b010, 32'd7, 32'hFFFFFFFE, busyCyc, doneCnt);
        checkOutput("div_negb_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_negb_hi", hi, 32'd1);

        applyStimulus(3'b010, 32'h80000000, 32'hFFFFFFFF, busyCyc, doneCnt);
        checkOutput("div_ovf_lo", lo, 32'h80000000);
        checkOutput("div_ovf_hi", hi, 32'h0);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = 3'b100; A = 32'h1234;
        @(negedge clk);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'b101; A = 32'h5678;
        @(negedge clk);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        checkOutput("mthi_hi", hi, 32'h1234);
        checkOutput("mtlo_lo", lo, 32'h5678);

        applyStimulus(3'b010, 32'd100, 32'd0, busyCyc, doneCnt);
        checkOutput("div0_busy_cycles", busyCyc, 32);
        checkOutput("div0_done_pulses", doneCnt, 1);
        checkOutput("div0_hi", hi, 32'h1234);
        checkOutput("div0_lo", lo, 32'h5678);

        // A MULT request mid-divide must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'b010; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        busyCyc = 0; doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busyCyc++;
            if (done) doneCnt++;
            start = (i == 10);
            op = 3'b000; A = 32'd3; B = 32'd3;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("ignore_busy_cycles", busyCyc, 32);
        checkOutput("ignore_lo", lo, 32'd14);
        checkOutput("ignore_hi", hi, 32'd2);

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 3'b011; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) doneCnt++;
            reset = (i == 20);
            @(negedge clk);
        end
        reset = 1'b0;
        checkOutput("abort_done_pulses", doneCnt, 0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_hi", hi, 32'h0);
        checkOutput("abort_lo", lo, 32'h0);

        // New start accepted in the same cycle done is high
        @(negedge clk);
        start = 1'b1; op = 3'b011; A = 32'd20; B = 32'd6;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        checkOutput("chain_done_seen", {31'd0, done}, 32'd1);
        checkOutput("chain_divu_lo", lo, 32'd3);
        start = 1'b1; op = 3'b000; A = 32'd2; B = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checkOutput("chain_accept_busy", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        checkOutput("chain_mult_lo", lo, 32'd4);
        checkOutput("chain_mult_hi", hi, 32'd0);

        applyStimulus(3'b100, 32'd0, 32'd0, busyCyc, doneCnt);
        applyStimulus(3'b101, 32'hFFFFFFFF, 32'd0, busyCyc, doneCnt);
        applyStimulus(3'b111, 32'd1, 32'd1, busyCyc, doneCnt);
`ifdef MDU_MADD_EN
        checkOutput("maddu_busy_cycles", busyCyc, 5);
        checkOutput("maddu_done_pulses", doneCnt, 1);
        checkOutput("maddu_hi", hi, 32'd1);
        checkOutput("maddu_lo", lo, 32'd0);
`else
        checkOutput("noop_busy_cycles", busyCyc, 0);
        checkOutput("noop_done_pulses", doneCnt, 0);
        checkOutput("noop_hi", hi, 32'd0);
        checkOutput("noop_lo", lo, 32'hFFFFFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
